vga_timing_driver: RTL and testbench

Raster timing generator and pixel output stage for the VGA display path. Produces the pixel coordinates `x`, `y` consumed by the pixel sources (animation and game renderers) and drives the monitor's sync and RGB pins. It accepts the 12-bit `color_data` those sources return a fixed number of cycles later. Sync and blanking are delay-matched to that pipeline, so every colour lands on the pixel whose coordinates produced it.

---
 rtl/vga_timing_driver.sv | 111 +++++++++++
 tb/tb_vga_timing_driver.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_driver.sv
// Raster timing generator and pixel output stage for the VGA display path.
// Ports: vgaClk/reset in; color_data in; x,y,active,frame_start,hsync,vsync,vga_r/g/b out.
module vga_timing_driver #(
  parameter int H_ACTIVE   = 1280,
  parameter int H_FP       = 48,
  parameter int H_SYNC     = 112,
  parameter int H_BP       = 248,
  parameter int V_ACTIVE   = 1024,
  parameter int V_FP       = 1,
  parameter int V_SYNC     = 3,
  parameter int V_BP       = 38,
  parameter bit SYNC_POL   = 1'b1,
  parameter int PIPE_DELAY = 2
) (
  input  logic        vgaClk,
  input  logic        reset,
  input  logic [11:0] color_data,
  output logic [11:0] x,
  output logic [11:0] y,
  output logic        active,
  output logic        frame_start,
  output logic        hsync,
  output logic        vsync,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b
);

  localparam logic [11:0] HT_M1 =
    12'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [11:0] VT_M1 =
    12'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [11:0] HA     = 12'(H_ACTIVE);
  localparam logic [11:0] VA     = 12'(V_ACTIVE);
  localparam logic [11:0] HS_ON  = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_OFF = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] VS_ON  = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] VS_OFF = 12'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic        IDLE   = ~SYNC_POL;

  logic [11:0] x_q, x_d;
  logic [11:0] y_q, y_d;
  logic        hs_raw, vs_raw;
  logic [2:0]  tap_in, tap_out;
  logic        hsync_q, vsync_q;
  logic [11:0] rgb_q;

  always_comb begin
    x_d = x_q + 12'd1;
    y_d = y_q;
    if (x_q == HT_M1) begin
      x_d = '0;
      y_d = (y_q == VT_M1) ? '0 : y_q + 12'd1;
    end
  end

  always_ff @(posedge vgaClk) begin
    if (reset) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign active      = (x_q < HA) && (y_q < VA);
  assign frame_start = (x_q == '0) && (y_q == '0);
  assign hs_raw      = (x_q >= HS_ON) && (x_q < HS_OFF);
  assign vs_raw      = (y_q >= VS_ON) && (y_q < VS_OFF);
  assign tap_in      = {hs_raw, vs_raw, active};

  // Delay line matching the colour source latency; bits are {hs, vs, act}.
  if (PIPE_DELAY == 0) begin : g_wire
    assign tap_out = tap_in;
  end else begin : g_pipe
    logic [2:0] pipe_q [PIPE_DELAY];
    always_ff @(posedge vgaClk) begin
      if (reset) begin
        for (int i = 0; i < PIPE_DELAY; i++)
          pipe_q[i] <= '0;
      end else begin
        pipe_q[0] <= tap_in;
        for (int i = 1; i < PIPE_DELAY; i++)
          pipe_q[i] <= pipe_q[i-1];
      end
    end
    assign tap_out = pipe_q[PIPE_DELAY-1];
  end

  always_ff @(posedge vgaClk) begin
    if (reset) begin
      hsync_q <= IDLE;
      vsync_q <= IDLE;
      rgb_q   <= '0;
    end else begin
      hsync_q <= tap_out[2] ? SYNC_POL : IDLE;
      vsync_q <= tap_out[1] ? SYNC_POL : IDLE;
      rgb_q   <= tap_out[0] ? color_data : 12'h000;
    end
  end

  assign x     = x_q;
  assign y     = y_q;
  assign hsync = hsync_q;
  assign vsync = vsync_q;
  assign vga_r = rgb_q[11:8];
  assign vga_g = rgb_q[7:4];
  assign vga_b = rgb_q[3:0];

endmodule

// File: tb/tb_vga_timing_driver.sv
// Bench for vga_timing_driver: arithmetic raster model plus literal checks.
// Three instances: default timing, small frame, small frame with inverted syncs.
module tb_vga_timing_driver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstA, rstB, rstC;
  int   tA = -1000, tB = -1000, tC = -1000;
  int   total = 0, bad = 0;

  logic [11:0] cdA, cdB, cdC;
  logic [11:0] xA, yA, xB, yB, xC, yC;
  logic aA, fA, hA, vA, aB, fB, hB, vB, aC, fC, hC, vC;
  logic [3:0] rA, gA, bA, rB, gB, bB, rC, gC, bC;
  wire  [11:0] rgbA = {rA, gA, bA};
  wire  [11:0] rgbB = {rB, gB, bB};
  wire  [11:0] rgbC = {rC, gC, bC};

  function automatic logic [11:0] src(int n, int ht, int vt);
    logic [11:0] sx, sy;
    if (n < 0) return 12'hFFF;
    sx = 12'(n % ht);
    sy = 12'((n / ht) % vt);
    return {sx[3:0], sy[3:0], 4'hA};
  endfunction

  assign cdA = src(tA - 2, 1688, 1066);
  assign cdB = src(tB - 2, 25, 14);
  assign cdC = src(tC, 16, 10);

  vga_timing_driver uA (
    .vgaClk(clk), .reset(rstA), .color_data(cdA),
    .x(xA), .y(yA), .active(aA), .frame_start(fA),
    .hsync(hA), .vsync(vA), .vga_r(rA), .vga_g(gA), .vga_b(bA));

  vga_timing_driver #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(4),
    .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(3),
    .SYNC_POL(1'b1), .PIPE_DELAY(2)
  ) uB (
    .vgaClk(clk), .reset(rstB), .color_data(cdB),
    .x(xB), .y(yB), .active(aB), .frame_start(fB),
    .hsync(hB), .vsync(vB), .vga_r(rB), .vga_g(gB), .vga_b(bB));

  vga_timing_driver #(
    .H_ACTIVE(10), .H_FP(1), .H_SYNC(2), .H_BP(3),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(1), .V_BP(2),
    .SYNC_POL(1'b0), .PIPE_DELAY(0)
  ) uC (
    .vgaClk(clk), .reset(rstC), .color_data(cdC),
    .x(xC), .y(yC), .active(aC), .frame_start(fC),
    .hsync(hC), .vsync(vC), .vga_r(rC), .vga_g(gC), .vga_b(bC));

  always @(posedge clk) begin
    tA <= rstA ? 0 : tA + 1;
    tB <= rstB ? 0 : tB + 1;
    tC <= rstC ? 0 : tC + 1;
  end

  task automatic cmp(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      if (bad <= 20)
        $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Position t cycles after reset release fully determines every output.
  task automatic model_chk(
    input string nm, input int t,
    input int ha, input int hf, input int hs, input int hb,
    input int va, input int vf, input int vs, input int vb,
    input int d, input logic pol,
    input logic [11:0] xo, input logic [11:0] yo,
    input logic ao, input logic fo, input logic ho, input logic vo,
    input logic [11:0] rgb);
    int ht, vt, ex, ey, p, px, py;
    logic eh, ev;
    logic [11:0] ergb;
    ht = ha + hf + hs + hb;
    vt = va + vf + vs + vb;
    ex = t % ht;
    ey = (t / ht) % vt;
    cmp({nm, " xy"}, {8'd0, xo, yo}, ex * 4096 + ey);
    cmp({nm, " act/fs"}, {30'd0, ao, fo},
        ((ex < ha && ey < va) ? 2 : 0) + ((ex == 0 && ey == 0) ? 1 : 0));
    p = t - d - 1;
    eh = 1'b0;
    ev = 1'b0;
    ergb = 12'h000;
    if (p >= 0) begin
      px = p % ht;
      py = (p / ht) % vt;
      eh = (px >= ha + hf) && (px < ha + hf + hs);
      ev = (py >= va + vf) && (py < va + vf + vs);
      if (px < ha && py < va) ergb = src(p, ht, vt);
    end
    cmp({nm, " sync"}, {30'd0, ho, vo},
        ((eh ? pol : !pol) ? 2 : 0) + ((ev ? pol : !pol) ? 1 : 0));
    cmp({nm, " rgb"}, {20'd0, rgb}, {20'd0, ergb});
  endtask

  int   act_cntA = 0, fs_cntB = 0, hs_riseB = 0, vs_riseB = 0;
  logic hB_p = 1'b0, vB_p = 1'b0;

  always @(negedge clk) begin
    if (tA >= 0)
      model_chk("A", tA, 1280, 48, 112, 248, 1024, 1, 3, 38, 2, 1'b1,
                xA, yA, aA, fA, hA, vA, rgbA);
    if (tB >= 0)
      model_chk("B", tB, 16, 2, 3, 4, 8, 1, 2, 3, 2, 1'b1,
                xB, yB, aB, fB, hB, vB, rgbB);
    if (tC >= 0)
      model_chk("C", tC, 10, 1, 2, 3, 6, 1, 1, 2, 0, 1'b0,
                xC, yC, aC, fC, hC, vC, rgbC);
    if (!rstA && tA >= 0 && tA < 1688 && aA) act_cntA++;
    if (!rstB && tB >= 0 && tB < 700) begin
      if (fB) fs_cntB++;
      if (tB >= 350 && hB && !hB_p) hs_riseB++;
      if (tB >= 350 && vB && !vB_p) vs_riseB++;
    end
    hB_p <= hB;
    vB_p <= vB;
  end

  task automatic wait_b(input int n);
    int g = 0;
    while (tB != n && g < 20000) begin
      @(negedge clk);
      g++;
    end
    if (tB != n) cmp("wait_b timeout", tB, n);
  endtask

  task automatic wait_a(input int n);
    int g = 0;
    while (!(tA == n && !rstA) && g < 20000) begin
      @(negedge clk);
      g++;
    end
    if (tA != n) cmp("wait_a timeout", tA, n);
  endtask

  initial begin
    rstA = 1'b1;
    rstB = 1'b1;
    rstC = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rstA = 1'b0;
    rstB = 1'b0;
    rstC = 1'b0;
    @(negedge clk);

    wait_b(0);
    cmp("A x0", {20'd0, xA}, 0);
    cmp("A fs0", {31'd0, fA}, 1);
    cmp("A act0", {31'd0, aA}, 1);
    cmp("A hs idle", {31'd0, hA}, 0);
    cmp("A rgb0", {20'd0, rgbA}, 0);
    cmp("C hs idle", {31'd0, hC}, 1);
    cmp("C vs idle", {31'd0, vC}, 1);
    wait_b(1);
    cmp("C rgb pix0", {20'd0, rgbC}, 12'h00A);
    wait_b(3);
    cmp("A rgb pix0", {20'd0, rgbA}, 12'h00A);
    wait_b(5);
    cmp("C rgb pix4", {20'd0, rgbC}, 12'h40A);
    wait_b(11);
    cmp("C hs pre", {31'd0, hC}, 1);
    cmp("C rgb blank", {20'd0, rgbC}, 0);
    wait_b(12);
    cmp("C hs on", {31'd0, hC}, 0);
    wait_b(13);
    cmp("C hs on2", {31'd0, hC}, 0);
    wait_b(14);
    cmp("C hs off", {31'd0, hC}, 1);
    wait_b(227);
    cmp("B vs pre", {31'd0, vB}, 0);
    wait_b(228);
    cmp("B vs rise", {31'd0, vB}, 1);
    wait_b(277);
    cmp("B vs last", {31'd0, vB}, 1);
    wait_b(278);
    cmp("B vs fall", {31'd0, vB}, 0);
    wait_b(700);
    cmp("B fs count", fs_cntB, 2);
    cmp("B hs per frame", hs_riseB, 14);
    cmp("B vs per frame", vs_riseB, 1);
    wait_b(1283);
    cmp("A rgb hblank", {20'd0, rgbA}, 0);
    wait_b(1328);
    cmp("A x1328", {20'd0, xA}, 1328);
    wait_b(1330);
    cmp("A hs pre", {31'd0, hA}, 0);
    wait_b(1331);
    cmp("A hs rise", {31'd0, hA}, 1);
    wait_b(1442);
    cmp("A hs last", {31'd0, hA}, 1);
    wait_b(1443);
    cmp("A hs fall", {31'd0, hA}, 0);
    wait_b(1687);
    cmp("A x end", {20'd0, xA}, 1687);
    cmp("A y end", {20'd0, yA}, 0);
    wait_b(1688);
    cmp("A x wrap", {20'd0, xA}, 0);
    cmp("A y step", {20'd0, yA}, 1);
    cmp("A active count", act_cntA, 1280);
    wait_b(1696);
    cmp("A rgb pix51", {20'd0, rgbA}, 12'h51A);

    wait_b(2188);
    cmp("A x500", {20'd0, xA}, 500);
    cmp("A y1", {20'd0, yA}, 1);
    rstA = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rstA = 1'b0;
    @(negedge clk);
    wait_a(0);
    cmp("A rst xy", {8'd0, xA, yA}, 0);
    cmp("A rst fs", {31'd0, fA}, 1);
    cmp("A rst hs", {31'd0, hA}, 0);
    cmp("A rst rgb", {20'd0, rgbA}, 0);
    wait_a(2);
    cmp("A rst rgb2", {20'd0, rgbA}, 0);
    wait_a(3);
    cmp("A rst pix0", {20'd0, rgbA}, 12'h00A);
    wait_a(1700);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
